// File: rtl/cotm32_pkg.sv
// Shared core constants and types for the cotm32 data-side memory path.
// Holds bus widths, data memory size and the dmem_arbiter FSM state encoding.
// No logic; imported by the arbiter and its winner-select helper.
package cotm32_pkg;

  localparam int XLEN           = 32;
  localparam int BYTE_WIDTH     = 8;
  localparam int DATA_MEM_SIZE  = 1024;
  localparam int DMEM_ARB_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_arb_state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select between the two dmem requesters (DMEM_ARB_RR_EN: round-robin, else port 0 priority).
// Latency: combinational pick; the tie pointer updates on the grant edge.
// Backpressure: the pointer only advances when the pick is actually taken by the FSM.
module dmem_arb_pick
  import cotm32_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      grant_take,
`endif
  input  logic [DMEM_ARB_PORTS-1:0] req_valid,
  output logic                      pick_vld,
  output logic                      pick_idx
);

  assign pick_vld = |req_valid;

`ifdef DMEM_ARB_RR_EN
  // ptr_q names the port that wins the next tie; it starts at the core port.
  logic ptr_q;

  // Tie goes to the pointer; a lone requester wins outright.
  always_comb begin
    pick_idx = req_valid[1];
    if (&req_valid) pick_idx = ptr_q;
  end

  // After every grant the other port becomes the favoured one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ptr_q <= 1'b0;
    else if (grant_take) ptr_q <= ~pick_idx;
  end
`else
  // Core port always wins; port 1 only when port 0 is silent.
  always_comb begin
    pick_idx = !req_valid[0] && req_valid[1];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_mem between the core LSU (port 0) and a DMA/debug master (port 1), one access at a time.
// Latency: handshake at edge N, memory access in cycle N+1, response valid from cycle N+2 (3 cycles min).
// Backpressure: ready is low outside IDLE; a response is held until its port's resp_ready. DMEM_ARB_RR_EN = round-robin.
module dmem_arbiter
  import cotm32_pkg::*;
#(
  parameter  int MEM_SIZE   = DATA_MEM_SIZE,
  parameter  int DATA_WIDTH = XLEN,
  localparam int NB         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [DMEM_ARB_PORTS-1:0]            i_req_valid,
  output logic [DMEM_ARB_PORTS-1:0]            o_req_ready,
  input  logic [DMEM_ARB_PORTS-1:0]            i_req_we,
  input  logic [DMEM_ARB_PORTS*XLEN-1:0]       i_req_addr,
  input  logic [DMEM_ARB_PORTS*DATA_WIDTH-1:0] i_req_wdata,
  input  logic [DMEM_ARB_PORTS*NB-1:0]         i_req_wstrb,
  output logic [DMEM_ARB_PORTS-1:0]            o_resp_valid,
  input  logic [DMEM_ARB_PORTS-1:0]            i_resp_ready,
  output logic [DATA_WIDTH-1:0]                o_resp_rdata,
  output logic                                 o_resp_err,
  output logic                                 o_mem_we,
  output logic [XLEN-1:0]                      o_mem_addr,
  output logic [DATA_WIDTH-1:0]                o_mem_wdata,
  output logic [NB-1:0]                        o_mem_wstrb,
  input  logic [DATA_WIDTH-1:0]                i_mem_rdata
);

  // One extra bit so addr + NB near the top of the address space cannot wrap into range.
  localparam logic [XLEN:0] NB_EXT   = (XLEN+1)'(NB);
  localparam logic [XLEN:0] SIZE_EXT = (XLEN+1)'(MEM_SIZE);

  dmem_arb_state_e       state_q;
  logic                  idx_q;
  logic                  we_q;
  logic [XLEN-1:0]       addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic                  resp_vld_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;

  logic pick_vld;
  logic pick_idx;
  logic take;
  logic in_access;
  logic range_err;

  dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .grant_take (take),
`endif
    .req_valid  (i_req_valid),
    .pick_vld   (pick_vld),
    .pick_idx   (pick_idx)
  );

  assign take      = i_rst_n && (state_q == IDLE) && pick_vld;
  assign in_access = (state_q == ACCESS);
  assign range_err = ({1'b0, addr_q} + NB_EXT) > SIZE_EXT;

  // Ready goes only to the current winner, and only while idle and out of reset.
  always_comb begin
    o_req_ready = '0;
    if (take) o_req_ready[pick_idx] = 1'b1;
  end

  // Response valid is steered to the port that owns the in-flight transaction.
  always_comb begin
    o_resp_valid = '0;
    if (resp_vld_q) o_resp_valid[idx_q] = 1'b1;
  end

  assign o_resp_rdata = resp_rdata_q;
  assign o_resp_err   = resp_err_q;

  // Memory port is quiet outside ACCESS; reset kills the write strobe in the same cycle.
  assign o_mem_we    = in_access && we_q && !range_err && i_rst_n;
  assign o_mem_addr  = in_access ? addr_q  : '0;
  assign o_mem_wdata = in_access ? wdata_q : '0;
  assign o_mem_wstrb = in_access ? wstrb_q : '0;

  // Request latch, single access cycle, then hold the response until the owner takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_vld_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            idx_q   <= pick_idx;
            we_q    <= pick_idx ? i_req_we[1] : i_req_we[0];
            addr_q  <= pick_idx ? i_req_addr[2*XLEN-1:XLEN] : i_req_addr[XLEN-1:0];
            wdata_q <= pick_idx ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                : i_req_wdata[DATA_WIDTH-1:0];
            wstrb_q <= pick_idx ? i_req_wstrb[2*NB-1:NB] : i_req_wstrb[NB-1:0];
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          resp_vld_q   <= 1'b1;
          resp_err_q   <= range_err;
          resp_rdata_q <= (we_q || range_err) ? '0 : i_mem_rdata;
          state_q      <= RESP;
        end
        RESP: begin
          if (i_resp_ready[idx_q]) begin
            resp_vld_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
